// File: rtl/uart_host.sv
// rtl/uart_host.sv - host-side UART master issuing 18-bit odd-parity regfile packets
module uart_host #(
    parameter int RSP_TIMEOUT = 2048,
    parameter int GAP_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       posi,
    input  logic       piso,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_parity_err,
    output logic       rsp_frame_err,
    output logic       rsp_addr_err,
    output logic       rsp_timeout
);
    localparam int TW = $clog2(RSP_TIMEOUT + 1) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RSP_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX       = 3'd1,
        WAIT_RSP = 3'd2,
        RX       = 3'd3,
        RSP      = 3'd4,
        GAP      = 3'd5
    } state_t;

    state_t state, state_next;

    logic [18:0]   tx_shift;
    logic [3:0]    tx_cyc;
    logic [4:0]    tx_idx;
    logic          is_read;
    logic [7:0]    req_addr;
    logic          piso_s1, piso_s2;
    logic [TW-1:0] to_cnt;
    logic [8:0]    rx_cnt;
    logic [17:0]   rx_shift;
    logic [GW-1:0] gap_cnt;

    logic          accept, tx_tick, rx_sample;
    logic [4:0]    rx_idx;
    logic [16:0]   tx_body;
    logic          posi_d;
    logic [7:0]    rsp_data_d;
    logic [3:0]    rsp_flags_d;

    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
    assign tx_tick   = (state == TX) && (tx_cyc == 4'd15);
    assign rx_idx    = rx_cnt[8:4];
    // rx_cnt counts cycles since the edge cycle, so mid-bit samples land on low nibble 7
    assign rx_sample = (state == RX) && (rx_cnt[3:0] == 4'd7);
    assign tx_body   = {cmd_addr, cmd_write ? cmd_wdata : 8'h00, cmd_write};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept) state_next = TX;
            TX:       if (tx_tick && tx_idx == 5'd19) state_next = is_read ? WAIT_RSP : RSP;
            WAIT_RSP: begin
                if (to_cnt >= TO_LAST) state_next = RSP;
                else if (!piso_s2)     state_next = RX;
            end
            RX: begin
                if (rx_sample) begin
                    if (rx_idx == 5'd0 && piso_s2) state_next = WAIT_RSP;
                    else if (rx_idx == 5'd19)      state_next = RSP;
                end
            end
            RSP:      state_next = GAP;
            GAP:      if (gap_cnt == GAP_LAST) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        posi_d      = 1'b1;
        rsp_data_d  = rsp_data;
        rsp_flags_d = {rsp_parity_err, rsp_frame_err, rsp_addr_err, rsp_timeout};
        if (state_next == TX)
            posi_d = accept ? 1'b0 : (tx_tick ? tx_shift[0] : posi);
        if (state_next == RSP) begin
            rsp_data_d  = 8'h00;
            rsp_flags_d = 4'b0000;
            if (state == WAIT_RSP) begin
                rsp_flags_d = 4'b0001;
            end else if (state == RX) begin
                // piso_s2 is the stop bit on this cycle; rx_shift holds the full packet
                rsp_flags_d = {~(^rx_shift), ~piso_s2,
                               (rx_shift[16:9] != req_addr) || rx_shift[0], 1'b0};
                if (rsp_flags_d == 4'b0000) rsp_data_d = rx_shift[8:1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            posi           <= 1'b1;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 8'h00;
            rsp_parity_err <= 1'b0;
            rsp_frame_err  <= 1'b0;
            rsp_addr_err   <= 1'b0;
            rsp_timeout    <= 1'b0;
            piso_s1        <= 1'b1;
            piso_s2        <= 1'b1;
            tx_shift       <= '0;
            tx_cyc         <= '0;
            tx_idx         <= '0;
            is_read        <= 1'b0;
            req_addr       <= 8'h00;
            to_cnt         <= '0;
            rx_cnt         <= '0;
            rx_shift       <= '0;
            gap_cnt        <= '0;
        end else begin
            piso_s1   <= piso;
            piso_s2   <= piso_s1;
            posi      <= posi_d;
            cmd_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RSP);
            rsp_data  <= rsp_data_d;
            {rsp_parity_err, rsp_frame_err, rsp_addr_err, rsp_timeout} <= rsp_flags_d;

            // start bit goes straight to posi, so the shifter holds {stop, packet}
            if (accept) begin
                tx_shift <= {1'b1, ~^tx_body, tx_body};
                tx_cyc   <= '0;
                tx_idx   <= '0;
                is_read  <= ~cmd_write;
                req_addr <= cmd_addr;
            end else if (state == TX) begin
                tx_cyc <= tx_cyc + 4'd1;
                if (tx_tick) begin
                    tx_shift <= {1'b1, tx_shift[18:1]};
                    tx_idx   <= tx_idx + 5'd1;
                end
            end

            // timeout budget spans false starts, so RX keeps counting
            if (state == TX)                              to_cnt <= '0;
            else if (state == WAIT_RSP || state == RX)    to_cnt <= to_cnt + TW'(1);

            if (state == WAIT_RSP)  rx_cnt <= 9'd1;
            else if (state == RX)   rx_cnt <= rx_cnt + 9'd1;

            if (rx_sample && rx_idx >= 5'd1 && rx_idx <= 5'd18)
                rx_shift <= {piso_s2, rx_shift[17:1]};

            if (state == RSP)       gap_cnt <= '0;
            else if (state == GAP)  gap_cnt <= gap_cnt + GW'(1);
        end
    end
endmodule

// File: tb/tb_uart_host.sv
// tb/tb_uart_host.sv - self-checking bench for uart_host with a behavioural slave model
module tb_uart_host;
    localparam int GAP_CYCLES = 32;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       piso = 1'b1;
    logic       cmd_ready, posi, rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_parity_err, rsp_frame_err, rsp_addr_err, rsp_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    uart_host #(.RSP_TIMEOUT(2048), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .posi(posi), .piso(piso),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_parity_err(rsp_parity_err), .rsp_frame_err(rsp_frame_err),
        .rsp_addr_err(rsp_addr_err), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    // modes: 0 clean reply, 1 parity flipped, 2 stop bit 0, 3 addr+1, 4 wrb=1,
    //        5 silent line, 6 silent line with a 4-cycle low glitch
    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         mode;
        logic [7:0] rdata;
        int         delay;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [17:0] make_pkt(input logic [7:0] a, input logic [7:0] d, input logic w);
        logic [16:0] body;
        body = {a, d, w};
        make_pkt = {($countones(body) % 2 == 0), body};
    endfunction

    function automatic logic [17:0] reply_pkt(input logic [7:0] a, input logic [7:0] rdata, input int mode);
        logic [17:0] p;
        p = make_pkt((mode == 3) ? a + 8'd1 : a, rdata, mode == 4);
        if (mode == 1) p[17] = ~p[17];
        return p;
    endfunction

    task automatic model_rsp(input logic w, input logic [7:0] a, input int mode, input logic [7:0] rdata,
                             output logic [7:0] data, output logic [3:0] flags);
        logic [17:0] p;
        logic pe, fe, ae;
        data = 8'h00;
        flags = 4'b0000;
        if (!w && mode >= 5) begin
            flags = 4'b0001;
        end else if (!w) begin
            p  = reply_pkt(a, rdata, mode);
            pe = ($countones(p) % 2 == 0);
            fe = (mode == 2);
            ae = (p[16:9] != a) || p[0];
            flags = {pe, fe, ae, 1'b0};
            if (!(pe || fe || ae)) data = p[8:1];
        end
    endtask

    task automatic run_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, input int mode,
                           input logic [7:0] rdata, input int delay,
                           input logic [7:0] exp_data, input logic [3:0] exp_flags);
        logic [19:0] exp_frame, reply;
        logic [7:0]  got_data;
        logic [3:0]  got_flags;
        int guard, posi_bad, rsp_cnt, rsp_j, ready_j, exp_rsp_j, s_j;
        exp_frame = {1'b1, make_pkt(a, w ? d : 8'h00, w), 1'b0};
        reply     = {(mode == 2) ? 1'b0 : 1'b1, reply_pkt(a, rdata, mode), 1'b0};
        s_j       = 320 + delay;
        exp_rsp_j = w ? 320 : (mode >= 5) ? 2368 : s_j + 314;
        posi_bad = 0; rsp_cnt = 0; rsp_j = -1; ready_j = -1;
        got_data = 8'hxx; got_flags = 4'hx;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        for (int j = 0; j < 4000; j++) begin
            if (j < 320) begin
                if ((j % 16 == 0 || j % 16 == 8 || j % 16 == 15) && posi !== exp_frame[j / 16]) posi_bad++;
            end else if (posi !== 1'b1) posi_bad++;
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (rsp_cnt == 1) begin
                    rsp_j = j;
                    got_data = rsp_data;
                    got_flags = {rsp_parity_err, rsp_frame_err, rsp_addr_err, rsp_timeout};
                end
            end
            if (cmd_ready === 1'b1) begin
                ready_j = j;
                break;
            end
            cmd_write = 1'($urandom);
            cmd_addr  = 8'($urandom);
            cmd_wdata = 8'($urandom);
            piso = 1'b1;
            if (!w && mode <= 4 && j >= s_j && j < s_j + 320) piso = reply[(j - s_j) / 16];
            if (!w && mode == 6 && j >= 399 && j <= 402) piso = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        piso = 1'b1;
        check("posi_frame_errs", posi_bad, 0);
        check("rsp_count", rsp_cnt, 1);
        check("rsp_cycle", rsp_j, exp_rsp_j);
        check("rsp_data", got_data, exp_data);
        check("rsp_flags", got_flags, exp_flags);
        check("rsp_hold", {rsp_data, rsp_parity_err, rsp_frame_err, rsp_addr_err, rsp_timeout},
              {exp_data, exp_flags});
        check("ready_cycle", ready_j, exp_rsp_j + 1 + GAP_CYCLES);
    endtask

    initial begin
        logic [7:0] ed;
        logic [3:0] ef;
        logic       rw;
        logic [7:0] ra, rd, rr;
        int         rm, bad, vcnt;

        vecs[0] = '{1'b1, 8'h12, 8'h34, 0, 8'h00, 0,  8'h00, 4'b0000};
        vecs[1] = '{1'b0, 8'h3C, 8'h77, 0, 8'hA5, 40, 8'hA5, 4'b0000};
        vecs[2] = '{1'b0, 8'h3C, 8'h00, 1, 8'hA5, 40, 8'h00, 4'b1000};
        vecs[3] = '{1'b0, 8'h3C, 8'h00, 2, 8'hA5, 40, 8'h00, 4'b0100};
        vecs[4] = '{1'b0, 8'h3C, 8'h00, 3, 8'hA5, 40, 8'h00, 4'b0010};
        vecs[5] = '{1'b0, 8'h81, 8'h00, 4, 8'h5A, 12, 8'h00, 4'b0010};
        vecs[6] = '{1'b0, 8'h3C, 8'h00, 5, 8'h00, 0,  8'h00, 4'b0001};
        vecs[7] = '{1'b0, 8'h3C, 8'h00, 6, 8'h00, 0,  8'h00, 4'b0001};
        vecs[8] = '{1'b1, 8'hFF, 8'h00, 0, 8'h00, 0,  8'h00, 4'b0000};

        repeat (3) @(negedge clk);
        check("reset_posi", posi, 1);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_rsp", {rsp_valid, rsp_data, rsp_parity_err, rsp_frame_err, rsp_addr_err, rsp_timeout}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        foreach (vecs[i])
            run_cmd(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].mode, vecs[i].rdata, vecs[i].delay,
                    vecs[i].exp_data, vecs[i].exp_flags);

        for (int k = 0; k < 6; k++) begin
            rw = ($urandom_range(0, 2) == 0);
            ra = 8'($urandom);
            rd = 8'($urandom);
            rr = 8'($urandom);
            rm = $urandom_range(0, 4);
            model_rsp(rw, ra, rm, rr, ed, ef);
            run_cmd(rw, ra, rd, rm, rr, $urandom_range(10, 60), ed, ef);
        end

        // reset in the middle of a write: data bit 7 of 0x55 is on the wire at T+150
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 8'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (149) @(negedge clk);
        check("posi_before_reset", posi, 0);
        reset_n = 1'b0;
        #1;
        check("posi_async_reset", posi, 1);
        check("ready_in_reset", cmd_ready, 0);
        bad = 0; vcnt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", cmd_ready, 1);
        repeat (400) begin
            if (rsp_valid === 1'b1) vcnt++;
            if (posi !== 1'b1) bad++;
            @(negedge clk);
        end
        check("no_rsp_after_midreset", vcnt, 0);
        check("posi_idle_after_midreset", bad, 0);
        run_cmd(1'b0, 8'h3C, 8'h00, 0, 8'hA5, 40, 8'hA5, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_host.md
# uart_host

Host-side (initiator) UART master for the on-chip regfile UART: it accepts parallel read/write commands, serialises them onto `posi` as 18-bit odd-parity packets, and for reads captures and checks the response packet returned on `piso`. It sits in the test FPGA/off-chip controller, or in an upstream chip of a daisy-chain, as the peer of the chip's UART slave. `clk` is 16× the serial bit rate, the same as the slave.

## Interface
- RSP_TIMEOUT, 2048: max `clk` cycles in WAIT_RSP before a read is abandoned.
- GAP_CYCLES, 32: idle-line cycles enforced after every command before `cmd_ready` reasserts (≥8 required for slave FSM turnaround).
- clk  input  1  controlling clock, 16× bit rate.
- reset_n  input  1  asynchronous reset, active low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted on a `clk` edge with `cmd_valid && cmd_ready`.
- cmd_write  input  1  1 = write, 0 = read; becomes packet bit 0 (wrb).
- cmd_addr  input  8  regfile address; packet bits 16:9.
- cmd_wdata  input  8  write data; packet bits 8:1; forced to 0x00 for reads.
- posi  output  1  serial out to chip; idle high.
- piso  input  1  serial in from chip; asynchronous, 2-flop synchronised internally.
- rsp_valid  output  1  one-cycle completion pulse, for both writes and reads.
- rsp_data  output  8  read data; 0x00 for writes, timeouts and errors; held until the next `rsp_valid`.
- rsp_parity_err  output  1  received 18 bits have even weight.
- rsp_frame_err  output  1  stop bit sampled 0.
- rsp_addr_err  output  1  response addr ≠ request addr, or response wrb = 1.
- rsp_timeout  output  1  no valid start bit within RSP_TIMEOUT.

## Operation
- Packet: {parity, addr[7:0], data[7:0], wrb}. parity = XNOR-reduce of bits 16:0, so the 18-bit word has odd weight.
- Frame on the wire: start 0, bits 0..17 LSB-first, stop 1; 20 bits, each held exactly 16 cycles.
- States:
  - IDLE → TX on accept. Command fields are latched at accept; later input changes are ignored.
  - TX → WAIT_RSP (read) or RSP (write) after the stop bit completes.
  - WAIT_RSP → RX on the first cycle synchronised `piso` = 0. Goes to RSP with timeout=1 when the count reaches RSP_TIMEOUT.
  - RX → RSP after the stop-bit sample. A false start returns to WAIT_RSP; the timeout count continues and does not reset.
  - RSP: one cycle, `rsp_valid` = 1, then GAP.
  - GAP → IDLE after GAP_CYCLES cycles.
- RX sampling: edge cycle E is the first synchronised low.
  - Start is re-checked at E+7. If high, it is a false start.
  - Bit k (0..17) is sampled at E+7+16(k+1).
  - Stop is sampled at E+311.
- Response checks:
  - Parity, stop bit, addr equality, wrb = 0.
  - Any error forces `rsp_data` = 0x00. Multiple error flags may be set together.
- Error flags are valid only with `rsp_valid` and are held with `rsp_data`.
- `piso` activity outside WAIT_RSP/RX is ignored.
- Undefined state encodings go to IDLE.

## Timing
- Reset values:
  - `posi` = 1, `cmd_ready` = 0 in reset, then 1 in IDLE on the first cycle after release.
  - `rsp_valid` = 0, `rsp_data` = 0x00, all error flags 0.
  - All counters 0, state IDLE.
- Accept at edge T gives this `posi` schedule:
  - Start bit drives cycles T+1..T+16.
  - Bit k drives T+17+16k..T+32+16k.
  - Stop drives T+305..T+320.
- Write: `rsp_valid` at T+321; `cmd_ready` high again at T+322+GAP_CYCLES.
- Read: WAIT_RSP begins T+321; `rsp_valid` at E+312 (timeout: cycle T+321+RSP_TIMEOUT).
- `posi` is registered with no glitches, and held high in every state except TX.
- Reset mid-operation: `posi` goes to 1 asynchronously and any in-flight command is dropped with no `rsp_valid`.
- Back-to-back commands are impossible by construction: the minimum spacing between accepts is 322+GAP_CYCLES cycles.

## Test plan
- Write, addr 0x12 data 0x34:
  - `posi` bits 0..17 = 1,0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0,1 at 16-cycle spacing, start at T+1, stop T+305..T+320.
  - `rsp_valid` at T+321 with all flags 0.
- Read addr 0x3C, behavioural slave replies after 40 cycles with addr 0x3C data 0xA5 wrb 0 parity 1:
  - Sent packet data field 0x00, parity 1.
  - `rsp_valid` once, `rsp_data` = 0xA5, flags 0, at E+312.
- Same read, reply parity flipped → `rsp_parity_err` = 1, `rsp_data` = 0x00. Reply stop bit 0 → `rsp_frame_err` = 1. Reply addr 0x3D → `rsp_addr_err` = 1.
- Read with `piso` held high → `rsp_timeout` = 1 at T+321+2048. Repeat with a 4-cycle low glitch at T+400 → no RX capture, timeout still at T+2369.
- `reset_n` low at T+150 of a write:
  - `posi` = 1 immediately, no `rsp_valid`.
  - After release, a new read completes correctly and the slave model sees no extra frame.
- Command inputs change during TX/GAP → transmitted bits unchanged, `cmd_ready` = 0 throughout, no second accept.
